// File: rtl/tilt_sensor_reader.sv
// SPI mode-3 master for an ADXL345-style accelerometer: runs a two-write init,
// then periodically burst-reads X/Y and publishes them as 11-bit signed tilt sines.
module tilt_sensor_reader #(
  parameter int unsigned CLK_DIV       = 25,
  parameter int unsigned SAMPLE_PERIOD = 500000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [10:0] sin_x,
  output logic [10:0] sin_y,
  output logic        sample_valid,
  output logic        busy
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {
    S_INIT_PWR,
    S_INIT_FMT,
    S_WAIT,
    S_READ,
    S_UPDATE
  } state_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_LO,
    PH_HI,
    PH_HOLD,
    PH_GAP
  } phase_t;

  state_t           state, state_n;
  phase_t           phase, phase_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [TMR_W-1:0] tmr, tmr_n;
  logic [2:0]       bit_idx, bit_n;
  logic [2:0]       byte_idx, byte_n;
  logic [2:0]       last_byte;
  logic             mosi_load;
  logic             shift_en;
  logic [7:0]       tx_byte;
  logic [31:0]      rx_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT_PWR;
      phase    <= PH_IDLE;
      div_cnt  <= '0;
      tmr      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      div_cnt  <= div_n;
      tmr      <= tmr_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
    end
  end

  // The sample timer free-runs and saturates, so a period shorter than a read
  // simply lets the next read start on the first WAIT cycle.
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    div_n     = div_cnt;
    bit_n     = bit_idx;
    byte_n    = byte_idx;
    tmr_n     = (tmr == TMR_LAST) ? tmr : tmr + TMR_W'(1);
    mosi_load = 1'b0;
    shift_en  = 1'b0;
    last_byte = (state == S_READ) ? 3'd4 : 3'd1;

    if (phase == PH_IDLE) begin
      case (state)
        S_WAIT: begin
          if (tmr == TMR_LAST) begin
            state_n = S_READ;
            phase_n = PH_SETUP;
            div_n   = '0;
            tmr_n   = '0;
          end
        end
        S_UPDATE: state_n = S_WAIT;
        default: begin
          phase_n = PH_SETUP;
          div_n   = '0;
        end
      endcase
    end else if (div_cnt != DIV_LAST) begin
      div_n = div_cnt + DIV_W'(1);
    end else begin
      div_n = '0;
      case (phase)
        PH_SETUP: begin
          phase_n   = PH_LO;
          bit_n     = '0;
          byte_n    = '0;
          mosi_load = 1'b1;
        end
        PH_LO: begin
          phase_n  = PH_HI;
          shift_en = (state == S_READ);
        end
        PH_HI: begin
          if (bit_idx != 3'd7) begin
            phase_n   = PH_LO;
            bit_n     = bit_idx + 3'd1;
            mosi_load = 1'b1;
          end else if (byte_idx != last_byte) begin
            phase_n   = PH_LO;
            bit_n     = '0;
            byte_n    = byte_idx + 3'd1;
            mosi_load = 1'b1;
          end else begin
            phase_n = PH_HOLD;
          end
        end
        PH_HOLD: phase_n = PH_GAP;
        PH_GAP: begin
          phase_n = PH_IDLE;
          case (state)
            S_INIT_PWR: begin
              state_n = S_INIT_FMT;
              phase_n = PH_SETUP;
            end
            S_INIT_FMT: begin
              state_n = S_WAIT;
              tmr_n   = '0;
            end
            S_READ:  state_n = S_UPDATE;
            default: state_n = state;
          endcase
        end
        default: phase_n = PH_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    case (state)
      S_INIT_PWR: tx_byte = (byte_n == 3'd0) ? 8'h2D : 8'h08;
      S_INIT_FMT: tx_byte = (byte_n == 3'd0) ? 8'h31 : 8'h00;
      S_READ:     tx_byte = (byte_n == 3'd0) ? 8'hF2 : 8'h00;
      default:    tx_byte = 8'h00;
    endcase
  end

  // SPI pins and sample outputs are registered from the next-state decode so
  // they line up exactly with the phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      spi_sclk     <= 1'b1;
      spi_cs_n     <= 1'b1;
      spi_mosi     <= 1'b0;
      rx_sr        <= '0;
      sin_x        <= '0;
      sin_y        <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b1;
    end else begin
      spi_cs_n     <= (phase_n == PH_IDLE) || (phase_n == PH_GAP);
      spi_sclk     <= (phase_n != PH_LO);
      sample_valid <= (state_n == S_UPDATE);
      busy         <= (state_n != S_WAIT);
      if (mosi_load) begin
        spi_mosi <= tx_byte[3'd7 - bit_n];
      end
      if (shift_en) begin
        rx_sr <= {rx_sr[30:0], spi_miso};
      end
      // rx_sr = {X0, X1, Y0, Y1}; keep the low 10 bits of each word, sign-extended
      if (state_n == S_UPDATE) begin
        sin_x <= {rx_sr[17], rx_sr[17:16], rx_sr[31:24]};
        sin_y <= {rx_sr[1], rx_sr[1:0], rx_sr[15:8]};
      end
    end
  end

endmodule

// File: tb/tb_tilt_sensor_reader.sv
// Bench for tilt_sensor_reader: SPI slave model with a sample scoreboard on one
// instance, and a back-to-back (period 1) instance checked for frame spacing.
module tb_tilt_sensor_reader;

  localparam int unsigned CD_A = 2;
  localparam int unsigned SP_A = 1000;
  localparam int unsigned CD_B = 1;
  localparam int unsigned SP_B = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b;
  logic        sclk_a, cs_a, mosi_a, sv_a, busy_a;
  logic        miso_a = 1'b0;
  logic [10:0] sin_x_a, sin_y_a;
  logic        sclk_b, cs_b, mosi_b, sv_b, busy_b;
  logic        miso_b = 1'b1;
  logic [10:0] sin_x_b, sin_y_b;

  tilt_sensor_reader #(.CLK_DIV(CD_A), .SAMPLE_PERIOD(SP_A)) dut_a (
    .clk(clk), .rst(rst_a), .spi_sclk(sclk_a), .spi_cs_n(cs_a), .spi_mosi(mosi_a),
    .spi_miso(miso_a), .sin_x(sin_x_a), .sin_y(sin_y_a), .sample_valid(sv_a), .busy(busy_a)
  );

  tilt_sensor_reader #(.CLK_DIV(CD_B), .SAMPLE_PERIOD(SP_B)) dut_b (
    .clk(clk), .rst(rst_b), .spi_sclk(sclk_b), .spi_cs_n(cs_b), .spi_mosi(mosi_b),
    .spi_miso(miso_b), .sin_x(sin_x_b), .sin_y(sin_y_b), .sample_valid(sv_b), .busy(busy_b)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] conv(input logic [7:0] lo, input logic [7:0] hi);
    logic signed [9:0]  raw;
    logic signed [10:0] wide;
    raw  = {hi[1:0], lo};
    wide = raw;
    return wide;
  endfunction

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI slave / MOSI decoder for instance A
  logic [7:0]  sx0, sx1, sy0, sy1;
  logic [39:0] slave_tx;
  logic [39:0] mosi_sr;
  int unsigned rise_cnt_a  = 0;
  int unsigned sclk_falls_a = 0;
  bit          in_frame_a  = 0;
  int unsigned frame_bits[$];
  logic [39:0] frame_data[$];
  logic [21:0] exp_q[$];

  always @(negedge cs_a) begin
    in_frame_a = 1;
    rise_cnt_a = 0;
    mosi_sr    = '0;
    slave_tx   = {8'h00, sx0, sx1, sy0, sy1};
  end

  always @(posedge sclk_a) begin
    if (cs_a === 1'b0) begin
      mosi_sr = {mosi_sr[38:0], mosi_a};
      rise_cnt_a++;
    end
  end

  always @(negedge sclk_a) begin
    sclk_falls_a++;
    if (cs_a === 1'b0 && rise_cnt_a < 40) miso_a = slave_tx[39 - rise_cnt_a];
  end

  always @(posedge cs_a) begin
    if (in_frame_a) begin
      in_frame_a = 0;
      frame_bits.push_back(rise_cnt_a);
      frame_data.push_back(mosi_sr);
      if (rise_cnt_a == 40 && mosi_sr[39:32] == 8'hF2)
        exp_q.push_back({conv(slave_tx[31:24], slave_tx[23:16]), conv(slave_tx[15:8], slave_tx[7:0])});
    end
  end

  bit prev_sv_a = 0;
  always @(negedge clk) begin
    logic [21:0] e;
    if (sv_a === 1'b1) begin
      check_eq("valid_single", prev_sv_a, 0);
      check_eq("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("sin_xy", {sin_x_a, sin_y_a}, e);
      end
    end
    prev_sv_a = (sv_a === 1'b1);
  end

  task automatic wait_valid_a(input int unsigned budget, output int unsigned at);
    bit seen;
    seen = 0;
    at   = 0;
    for (int unsigned i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (sv_a === 1'b1) begin
        seen = 1;
        at   = cyc;
      end
    end
    check_eq("valid_timeout", seen, 1);
  endtask

  int unsigned t0, at, at_prev, nf, n, gap, pulses, idle, low;
  bit          seen;
  localparam int unsigned LAT_A = 2 * 35 * CD_A + SP_A + 83 * CD_A + 1;

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    sx0 = 8'h40; sx1 = 8'h00; sy0 = 8'hC0; sy1 = 8'h03;
    repeat (3) @(negedge clk);
    check_eq("reset_outs", {cs_a, sclk_a, mosi_a, sv_a, busy_a, sin_x_a, sin_y_a},
             {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 11'd0, 11'd0});
    check_eq("reset_no_sclk", sclk_falls_a, 0);
    check_eq("reset_outs_b", {cs_b, sclk_b, sv_b, busy_b}, {1'b1, 1'b1, 1'b0, 1'b1});

    rst_a = 1'b0;
    rst_b = 1'b0;
    t0 = cyc;
    wait_valid_a(3000, at);
    check_eq("first_latency", at - t0, LAT_A);
    check_eq("first_sin", {sin_x_a, sin_y_a}, {11'h040, 11'h7C0});
    check_eq("frame_count", frame_bits.size(), 3);
    if (frame_bits.size() >= 3) begin
      check_eq("pwr_bits", frame_bits[0], 16);
      check_eq("pwr_mosi", frame_data[0], 40'h2D08);
      check_eq("fmt_bits", frame_bits[1], 16);
      check_eq("fmt_mosi", frame_data[1], 40'h3100);
      check_eq("read_bits", frame_bits[2], 40);
      check_eq("read_mosi", frame_data[2], 40'hF2_0000_0000);
    end
    @(negedge clk);
    check_eq("busy_wait", {busy_a, cs_a}, {1'b0, 1'b1});

    // Periodicity, full-range values, ignored upper bits
    sx0 = 8'hFF; sx1 = 8'h01; sy0 = 8'h00; sy1 = 8'h02;
    at_prev = at;
    wait_valid_a(1200, at);
    check_eq("period_1", at - at_prev, SP_A);
    check_eq("extremes", {sin_x_a, sin_y_a}, {11'h1FF, 11'h600});
    sx0 = 8'h34; sx1 = 8'hFC; sy0 = 8'h01; sy1 = 8'hFD;
    at_prev = at;
    wait_valid_a(1200, at);
    check_eq("period_2", at - at_prev, SP_A);

    // Reset in the 3rd byte of a read
    seen = 0;
    for (int unsigned i = 0; i < 1500 && !seen; i++) begin
      @(negedge clk);
      if (in_frame_a && rise_cnt_a == 18 && sclk_a === 1'b1) seen = 1;
    end
    check_eq("midread_reached", seen, 1);
    check_eq("busy_in_read", busy_a, 1);
    rst_a = 1'b1;
    @(negedge clk);
    check_eq("midread_reset", {cs_a, sclk_a, sv_a, busy_a, sin_x_a, sin_y_a},
             {1'b1, 1'b1, 1'b0, 1'b1, 11'd0, 11'd0});
    check_eq("no_partial_push", exp_q.size(), 0);
    rst_a = 1'b0;
    t0 = cyc;
    nf = frame_bits.size();
    wait_valid_a(3000, at);
    check_eq("relatency", at - t0, LAT_A);
    check_eq("reinit_count", frame_bits.size(), nf + 3);
    if (nf >= 1 && frame_bits.size() >= nf + 3) begin
      check_eq("aborted_bits", frame_bits[nf-1], 18);
      check_eq("reinit_pwr", frame_data[nf], 40'h2D08);
      check_eq("reinit_fmt", frame_data[nf+1], 40'h3100);
      check_eq("reinit_read", frame_data[nf+2], 40'hF2_0000_0000);
    end

    // Back-to-back reads on instance B: GAP + UPDATE + WAIT between frames
    n = 0;
    while (cs_b === 1'b1 && n < 300) begin @(negedge clk); n++; end
    n = 0;
    while (cs_b === 1'b0 && n < 300) begin @(negedge clk); n++; end
    check_eq("b_align", cs_b, 1);
    for (int k = 0; k < 3; k++) begin
      gap = 0; pulses = 0; idle = 0;
      while (cs_b === 1'b1 && gap < 50) begin
        gap++;
        if (sv_b === 1'b1) begin
          pulses++;
          check_eq("b_sin", {sin_x_b, sin_y_b}, {conv(8'hFF, 8'hFF), conv(8'hFF, 8'hFF)});
        end
        if (busy_b === 1'b0) idle++;
        @(negedge clk);
      end
      check_eq("b_gap", gap, CD_B + 2);
      check_eq("b_pulses", pulses, 1);
      check_eq("b_idle", idle, 1);
      low = 0;
      while (cs_b === 1'b0 && low < 300) begin low++; @(negedge clk); end
      check_eq("b_frame", low, 82 * CD_B);
    end

    check_eq("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
